// File: rtl/instr_fetch_uni.sv
// -----------------------------------------------------------------------------
// instr_fetch_uni
// Instruction fetch stage for the uniciclo RISC-V core. Holds the PC, fetches
// one 32-bit word per instruction over a req/ack handshake, holds it for the
// core until iExecDone, then selects the next PC from the PC-origin code.
//
// Handshake: oIMemReq stays high (address stable) for every FETCH cycle until
// iIMemAck is seen at a rising edge; the word is captured on that same edge.
// Acks outside FETCH and iExecDone outside HOLD have no effect.
//
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN
//   defined   : a next PC with bits[1:0]!=00 traps into FAULT (left by reset)
//   undefined : next-PC bits[1:0] are forced to 00, oFault is tied low
//
// Ports
//   iCLK, iRSTn                 clock, synchronous active-low reset
//   iOrigPC[1:0]                next-PC select (00 PC+4, 01 branch, 10 JAL, 11 JALR)
//   iBranchTaken, iBranchTarget branch condition and target
//   iJalTarget, iJalrTarget     jump targets (JALR bit 0 cleared here)
//   iExecDone                   core consumed oInstr this cycle
//   oIMemReq, oIMemAddr         fetch request / address
//   iIMemData, iIMemAck         fetched word / acknowledge
//   oPC, oPC4                   PC of held instruction and PC+4
//   oInstr, oInstrValid         held instruction and its valid flag
//   oInstrCount                 retired-instruction counter (wraps silently)
//   oFault                      misaligned fetch-target trap
//   oDbgState[1:0]              FSM state (0 FETCH, 1 HOLD, 2 FAULT)
// -----------------------------------------------------------------------------
module instr_fetch_uni #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic [1:0]  iOrigPC,
    input  logic        iBranchTaken,
    input  logic [31:0] iBranchTarget,
    input  logic [31:0] iJalTarget,
    input  logic [31:0] iJalrTarget,
    input  logic        iExecDone,
    output logic        oIMemReq,
    output logic [31:0] oIMemAddr,
    input  logic [31:0] iIMemData,
    input  logic        iIMemAck,
    output logic [31:0] oPC,
    output logic [31:0] oPC4,
    output logic [31:0] oInstr,
    output logic        oInstrValid,
    output logic [31:0] oInstrCount,
    output logic        oFault,
    output logic [1:0]  oDbgState
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instrValid;
    logic [31:0] instrCount;

    logic [31:0] pcPlus4;
    logic [31:0] target;
    logic [31:0] nextPc;
    logic        misaligned;

    assign pcPlus4 = pc + 32'd4;

    // Raw target chosen by the control unit's PC-origin code.
    always_comb begin
        target = pcPlus4;
        case (iOrigPC)
            2'b00:   target = pcPlus4;
            2'b01:   target = iBranchTaken ? iBranchTarget : pcPlus4;
            2'b10:   target = iJalTarget;
            default: target = {iJalrTarget[31:1], 1'b0};
        endcase
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    // Keep the offending target so the PC freezes on it inside FAULT.
    assign nextPc     = target;
    assign misaligned = (target[1:0] != 2'b00);
`else
    // Without the trap, the low bits are simply dropped.
    assign nextPc     = {target[31:2], 2'b00};
    assign misaligned = 1'b0;
`endif

    // State and datapath registers; reset wins over ack, exec and fault.
    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            instr      <= NOP_WORD;
            instrValid <= 1'b0;
            instrCount <= 32'd0;
        end else begin
            state <= stateNext;
            case (state)
                S_FETCH: begin
                    if (iIMemAck) begin
                        instr      <= iIMemData;
                        instrValid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (iExecDone) begin
                        pc         <= nextPc;
                        instrValid <= 1'b0;
                        instrCount <= instrCount + 32'd1;
                        instr      <= NOP_WORD;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            S_FETCH: if (iIMemAck)  stateNext = S_HOLD;
            S_HOLD:  if (iExecDone) stateNext = misaligned ? S_FAULT : S_FETCH;
            default: stateNext = S_FAULT;
        endcase
    end

    // Outputs are decoded from registered state; iRSTn only gates the
    // request so it is quiet for the whole time reset is held.
    always_comb begin
        oIMemReq  = iRSTn && (state == S_FETCH);
`ifdef IFETCH_MISALIGN_TRAP_EN
        oFault    = (state == S_FAULT);
`else
        oFault    = 1'b0;
`endif
        oIMemAddr = pc;
        oDbgState = state;
    end

    assign oPC         = pc;
    assign oPC4        = pcPlus4;
    assign oInstr      = instr;
    assign oInstrValid = instrValid;
    assign oInstrCount = instrCount;

endmodule
